// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from per-bit JK cells, with sync load,
// terminal count and a registered wrap pulse. Define GRAY_OUT_EN to add gray_count.

module jk_cell #(
  parameter logic RV = 1'b0
) (
  input  logic clck,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clck or posedge reset) begin
    if (reset) q <= RV;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_mod_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 12,
  parameter int RESET_VALUE = 0
) (
  input  logic             clck,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray_count
`endif
);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  typedef enum logic [1:0] {M_HOLD, M_CNT, M_LOAD} mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j, k;
  logic             wrap_nxt;
  logic             at_max, at_zero, legal;

  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);
  assign legal   = ({1'b0, count} < MOD_W);
  assign tc      = en & ~load & (up ? at_max : at_zero);

  always_comb begin
    mode     = M_HOLD;
    nxt      = count;
    wrap_nxt = 1'b0;
    if (load) begin
      mode = M_LOAD;
      nxt  = ({1'b0, load_val} < MOD_W) ? load_val : MAX;
    end else if (en) begin
      mode = M_CNT;
      if (!legal) nxt = '0;  // recover from an upset state without flagging a wrap
      else if (up) begin
        if (at_max) begin nxt = '0; wrap_nxt = 1'b1; end
        else nxt = count + 1'b1;
      end else begin
        if (at_zero) begin nxt = MAX; wrap_nxt = 1'b1; end
        else nxt = count - 1'b1;
      end
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    case (mode)
      M_CNT:   begin j = count ^ nxt; k = count ^ nxt; end
      M_LOAD:  begin j = nxt;         k = ~nxt;        end
      default: begin j = '0;          k = '0;          end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell #(.RV(RST_V[i])) u_cell (
      .clck (clck),
      .reset(reset),
      .j    (j[i]),
      .k    (k[i]),
      .q    (count[i])
    );
  end

  always_ff @(posedge clck or posedge reset) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= wrap_nxt;
  end

`ifdef GRAY_OUT_EN
  assign gray_count = count ^ (count >> 1);
`endif
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=12); checks gray_count when GRAY_OUT_EN is defined.

module tb_jk_mod_counter;
  logic       clck = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrap;
`ifdef GRAY_OUT_EN
  logic [3:0] gray_count;
  logic [3:0] g_prev;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(12), .RESET_VALUE(0)) dut (
    .clck    (clck),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tc      (tc),
    .wrap    (wrap)
`ifdef GRAY_OUT_EN
    ,
    .gray_count(gray_count)
`endif
  );

  always #5 clck = ~clck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle just past it
  task automatic step();
    @(posedge clck);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    #2;
    chk("reset_count", count, 4'd0);
    chk("reset_wrap", wrap, 1'b0);
`ifdef GRAY_OUT_EN
    chk("reset_gray", gray_count, 4'b0000);
`endif
    @(negedge clck);
    reset = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("count_to_7", count, 4'd7);

    // async reset between edges
    #2 reset = 1'b1;
    #1;
    chk("midreset_count", count, 4'd0);
    chk("midreset_wrap", wrap, 1'b0);
    #1 reset = 1'b0;
    step();
    chk("post_reset_first_edge", count, 4'd1);
    chk("post_reset_wrap", wrap, 1'b0);

    // full up cycle from 0
    load = 1'b1; load_val = 4'd0;
    step();
    chk("load0", count, 4'd0);
    load = 1'b0;
    e = 4'd0;
    for (int i = 0; i < 12; i++) begin
      chk("up_tc", tc, (e == 4'd11));
`ifdef GRAY_OUT_EN
      g_prev = gray_count;
`endif
      step();
      e = (e == 4'd11) ? 4'd0 : e + 4'd1;
      chk("up_count", count, e);
      chk("up_wrap", wrap, (e == 4'd0));
`ifdef GRAY_OUT_EN
      if (e != 4'd0) chk("gray_one_bit", $countones(gray_count ^ g_prev), 1);
`endif
    end
`ifdef GRAY_OUT_EN
    chk("gray_of_0", gray_count, 4'b0000);
`endif

    // down wrap
    up = 1'b0;
    #1;
    chk("down_tc_at0", tc, 1'b1);
    step();
    chk("down_wrap_count", count, 4'd11);
    chk("down_wrap_pulse", wrap, 1'b1);
    step();
    chk("down_count_10", count, 4'd10);
    chk("down_wrap_clear", wrap, 1'b0);

    // loads
    up = 1'b1; load = 1'b1; load_val = 4'd3;
    step();
    chk("load3", count, 4'd3);
    load_val = 4'd5; en = 1'b1;
    step();
    chk("load_priority", count, 4'd5);
    chk("load_tc", tc, 1'b0);
    load_val = 4'd14;
    step();
    chk("load_clamp14", count, 4'd11);
    #1;
    chk("tc_masked_by_load", tc, 1'b0);
`ifdef GRAY_OUT_EN
    chk("gray_of_11", gray_count, 4'b1110);
`endif
    load_val = 4'd12;
    step();
    chk("load_clamp12", count, 4'd11);
    load = 1'b0;
    #1;
    chk("tc_at_11", tc, 1'b1);

    // hold
    load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_count", count, 4'd6);
      chk("hold_tc", tc, 1'b0);
      chk("hold_wrap", wrap, 1'b0);
    end

    // illegal state recovery
    @(negedge clck);
    force dut.g_bit[0].u_cell.q = 1'b1;
    force dut.g_bit[1].u_cell.q = 1'b0;
    force dut.g_bit[2].u_cell.q = 1'b1;
    force dut.g_bit[3].u_cell.q = 1'b1;
    #1;
    release dut.g_bit[0].u_cell.q;
    release dut.g_bit[1].u_cell.q;
    release dut.g_bit[2].u_cell.q;
    release dut.g_bit[3].u_cell.q;
    #1;
    chk("forced_13", count, 4'd13);
    en = 1'b1; up = 1'b1;
    #1;
    chk("illegal_tc", tc, 1'b0);
    step();
    chk("illegal_recover", count, 4'd0);
    chk("illegal_wrap", wrap, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule
